// File: rtl/ring_code_monitor_pkg.sv
// Shared types and helpers for the one-hot ring code monitor.
// Holds the monitor state encoding and the width-agnostic ring helpers
// (left rotation by one position and the one-hot legality test).
package ring_mon_pkg;

    // Widest ring the helper functions can handle; callers zero-extend into this.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Rotate the low 'width' bits of v left by one: bit i -> i+1, top bit -> bit 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        r    = ((v << 1) | (v >> (width - 1))) & mask;
        return r;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ring_code_monitor_onehot_to_bin.sv
// Combinational one-hot to binary decoder for the ring code monitor.
// The index is only meaningful when legal_o is high; for an illegal
// pattern it is the OR of the indices of all set bits.
module onehot_to_bin
    import ring_mon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_i,
    output logic [IW-1:0]    idx_o,
    output logic             legal_o
);

    // Encode the hot bit position and flag whether the pattern is one-hot.
    always_comb begin
        idx_o   = '0;
        legal_o = is_onehot(MAX_W'(ring_i));
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_i[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/ring_code_monitor.sv
// Receiving end of a one-hot ring counter code.
// Checks that each valid sample is one-hot and is the previous accepted
// sample rotated left by one, decodes the hot position, tracks lock,
// flags violations while locked and counts completed revolutions.
// Optional build macro: RING_HOLD_TOL_EN -- when defined, a sample equal
// to the previous accepted sample in ACQUIRE or LOCKED is treated as a
// stall (no state change, no error) instead of a mismatch.
module ring_code_monitor
    import ring_mon_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     ring_vld,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_vld,
    output logic                     locked,
    output logic                     err,
    output logic                     wrap,
    output logic [REV_W-1:0]         rev_cnt,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_CNT + 1);

    state_t           state_q,    state_d;
    logic [CW-1:0]    matchCnt_q, matchCnt_d;
    logic [WIDTH-1:0] prevRing_q, prevRing_d;
    logic [IW-1:0]    idx_q,      idx_d;
    logic             idxVld_q,   idxVld_d;
    logic             err_q,      err_d;
    logic             wrap_q,     wrap_d;
    logic [REV_W-1:0] revCnt_q,   revCnt_d;
    logic [ERR_W-1:0] errCnt_q,   errCnt_d;

    logic [IW-1:0]    sampleIdx;
    logic             sampleLegal;
    logic [WIDTH-1:0] expectedRing;
    logic             sampleMatch;
    logic             stall;
    logic [CW-1:0]    cntInc;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decode (
        .ring_i  (ring_in),
        .idx_o   (sampleIdx),
        .legal_o (sampleLegal)
    );

    assign expectedRing = WIDTH'(rotl1(MAX_W'(prevRing_q), WIDTH));
    assign sampleMatch  = sampleLegal && (ring_in == expectedRing);
    assign cntInc       = matchCnt_q + CW'(1);

`ifdef RING_HOLD_TOL_EN
    // A repeat of the last accepted sample is a stall once we are tracking a sequence.
    assign stall = (state_q != SEARCH) && (ring_in == prevRing_q);
`else
    assign stall = 1'b0;
`endif

    // Next-state logic: decide acceptance, lock progress, errors and revolutions.
    always_comb begin
        state_d    = state_q;
        matchCnt_d = matchCnt_q;
        prevRing_d = prevRing_q;
        idx_d      = idx_q;
        idxVld_d   = 1'b0;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        revCnt_d   = revCnt_q;
        errCnt_d   = errCnt_q;

        if (ring_vld && !stall) begin
            case (state_q)
                SEARCH: begin
                    if (sampleLegal) begin
                        idx_d      = sampleIdx;
                        idxVld_d   = 1'b1;
                        prevRing_d = ring_in;
                        matchCnt_d = CW'(1);
                        state_d    = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (sampleMatch) begin
                        idx_d      = sampleIdx;
                        idxVld_d   = 1'b1;
                        prevRing_d = ring_in;
                        matchCnt_d = cntInc;
                        if (cntInc >= CW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else if (sampleLegal) begin
                        idx_d      = sampleIdx;
                        idxVld_d   = 1'b1;
                        prevRing_d = ring_in;
                        matchCnt_d = CW'(1);
                        state_d    = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                    end else begin
                        matchCnt_d = '0;
                        state_d    = SEARCH;
                    end
                end
                LOCKED: begin
                    if (sampleMatch) begin
                        idx_d      = sampleIdx;
                        idxVld_d   = 1'b1;
                        prevRing_d = ring_in;
                        if ((idx_q == IW'(WIDTH - 1)) && (sampleIdx == '0)) begin
                            wrap_d   = 1'b1;
                            revCnt_d = revCnt_q + REV_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (errCnt_q != '1) begin
                            errCnt_d = errCnt_q + ERR_W'(1);
                        end
                        if (sampleLegal) begin
                            idx_d      = sampleIdx;
                            idxVld_d   = 1'b1;
                            prevRing_d = ring_in;
                            matchCnt_d = CW'(1);
                            state_d    = ACQUIRE;
                        end else begin
                            matchCnt_d = '0;
                            state_d    = SEARCH;
                        end
                    end
                end
                default: begin
                    matchCnt_d = '0;
                    state_d    = SEARCH;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority over samples.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= SEARCH;
            matchCnt_q <= '0;
            prevRing_q <= '0;
            idx_q      <= '0;
            idxVld_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            revCnt_q   <= '0;
            errCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            matchCnt_q <= matchCnt_d;
            prevRing_q <= prevRing_d;
            idx_q      <= idx_d;
            idxVld_q   <= idxVld_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            revCnt_q   <= revCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = idxVld_q;
    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign rev_cnt = revCnt_q;
    assign err_cnt = errCnt_q;

endmodule
